// File: rtl/div_sched.sv
// -----------------------------------------------------------------------------
// div_sched
//
// Sequencer and two-port round-robin arbiter for a shared 8-bit by 4-bit
// restoring shift-subtract divider. Two requesters present operands on a level
// request line. The block grants one of them and runs NSTEP shift/compare/
// subtract iterations. It then pulses done together with the quotient,
// remainder and the id of the requester that was served.
//
// Ports
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   req      in   2   level request, bit i = requester i
//   dvd0     in   8   dividend of requester 0
//   dvd1     in   8   dividend of requester 1
//   dvs0     in   4   divisor of requester 0
//   dvs1     in   4   divisor of requester 1
//   gnt      out  2   one-hot grant, high from capture through the DONE cycle
//   busy     out  1   high while in RUN or DONE
//   done     out  1   one-cycle completion pulse
//   done_id  out  1   requester served by the current/last result
//   quo      out  8   quotient, held until the next completion
//   rem      out  4   remainder, held until the next completion
//   div0     out  1   last result was a divide-by-zero
// -----------------------------------------------------------------------------
module div_sched #(
    parameter int NSTEP = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [7:0] dvd0,
    input  logic [7:0] dvd1,
    input  logic [3:0] dvs0,
    input  logic [3:0] dvs1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [7:0] quo,
    output logic [3:0] rem,
    output logic       div0
);

    localparam int CW = $clog2(NSTEP + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    logic [CW-1:0] cnt_q;
    logic         lastId_q;

    // Working registers of the divider: partial remainder, shifting
    // dividend/quotient, and the captured divisor.
    logic [4:0]   workRem_q;
    logic [7:0]   workQuo_q;
    logic [3:0]   workDvs_q;

    // Registered outputs.
    logic [1:0]   gnt_q;
    logic         busy_q;
    logic         done_q;
    logic         doneId_q;
    logic [7:0]   quo_q;
    logic [3:0]   rem_q;
    logic         div0_q;

    // One iteration of the restoring divider.
    logic [4:0]   shifted;
    logic         fits;
    logic [4:0]   workRem_d;
    logic [7:0]   workQuo_d;

    // Arbitration and the operands of the winner.
    logic         winId;
    logic [7:0]   capDvd;
    logic [3:0]   capDvs;
    logic         lastStep;

    // The remainder is always below the divisor before a shift, so its top bit
    // stays zero in the register. It only gains meaning in the shifted value.
    logic         unusedRemMsb;
    assign unusedRemMsb = workRem_q[4];

    // The shift moves the dividend MSB into the remainder. If the divisor fits
    // into the shifted remainder, it is subtracted and a 1 enters the quotient.
    always_comb begin
        shifted   = {workRem_q[3:0], workQuo_q[7]};
        fits      = (shifted >= {1'b0, workDvs_q});
        workRem_d = shifted;
        workQuo_d = {workQuo_q[6:0], 1'b0};
        if (fits) begin
            workRem_d    = shifted - {1'b0, workDvs_q};
            workQuo_d[0] = 1'b1;
        end
    end

    // A lone requester wins outright. On a tie the requester not served last
    // time wins, so a permanently asserted pair alternates 0,1,0,1.
    always_comb begin
        winId  = req[1] & (~req[0] | ~lastId_q);
        capDvd = winId ? dvd1 : dvd0;
        capDvs = winId ? dvs1 : dvs0;
    end

    assign lastStep = (cnt_q == CW'(NSTEP - 1));

    // Sequencer FSM. Requests are only looked at in IDLE. Every output is
    // produced here so that there is no combinational path from req to them.
    // Results change only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lastId_q  <= 1'b1;
            workRem_q <= '0;
            workQuo_q <= '0;
            workDvs_q <= '0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            doneId_q  <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            div0_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        lastId_q  <= winId;
                        gnt_q     <= winId ? 2'b10 : 2'b01;
                        busy_q    <= 1'b1;
                        workRem_q <= '0;
                        workQuo_q <= capDvd;
                        workDvs_q <= capDvs;
                        cnt_q     <= '0;
                        if (capDvs == 4'd0) begin
                            // Divide by zero skips the iterations entirely.
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            quo_q    <= 8'hFF;
                            rem_q    <= 4'h0;
                            div0_q   <= 1'b1;
                            doneId_q <= winId;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    workRem_q <= workRem_d;
                    workQuo_q <= workQuo_d;
                    cnt_q     <= cnt_q + CW'(1);
                    if (lastStep) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        quo_q    <= workQuo_d;
                        rem_q    <= workRem_d[3:0];
                        div0_q   <= 1'b0;
                        doneId_q <= lastId_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = doneId_q;
    assign quo     = quo_q;
    assign rem     = rem_q;
    assign div0    = div0_q;

endmodule
